// File: rtl/control_unit_if.sv
// Strobe bus between the hardwired control unit and the datapath.
// The control unit sits on the master side: it sees the instruction word and
// the condition flag, and it drives every datapath strobe plus the run flag.
interface control_unit_if;
    logic [31:0] ir;
    logic        branch_compare;
    logic [4:0]  op;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic        Read, Write;
    logic        Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
    logic        InPortout, OutPortin, CONin;
    logic        run;

    modport master (
        input  ir, branch_compare,
        output op,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        output Read, Write,
        output Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
        output InPortout, OutPortin, CONin,
        output run
    );

    modport slave (
        output ir, branch_compare,
        input  op,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        input  Read, Write,
        input  Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
        input  InPortout, OutPortin, CONin,
        input  run
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore control unit: RESET, fetch T0-T2, execute T3-T7, HALT.
// Strobes decode from the current state and the opcode in ir[31:27].
module control_unit (
    input  logic           clock,
    input  logic           clear,
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LD, C_LDI, C_ST, C_MULDIV, C_BR,
        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_NOP
    } class_e;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;

    state_e     state_q, state_d;
    logic       hold_q;       // keeps the FSM in RESET for the first edge after clear drops
    class_e     cls;
    logic [4:0] opcode;
    logic [4:0] imm_op;
    logic       unused_ir;

    assign opcode    = bus.ir[31:27];
    assign unused_ir = ^bus.ir[26:0];
    assign bus.run   = (state_q != S_RESET) && (state_q != S_HALT);

    // Classify the opcode into the instruction families that share a sequence.
    always_comb begin
        cls = C_NOP;
        case (opcode) inside
            [5'd3:5'd11]:  cls = C_ALU;
            [5'd12:5'd14]: cls = C_IMM;
            5'd15, 5'd16:  cls = C_MULDIV;
            5'd0:          cls = C_LD;
            5'd1:          cls = C_LDI;
            5'd2:          cls = C_ST;
            5'd18:         cls = C_BR;
            5'd19:         cls = C_JR;
            5'd22:         cls = C_IN;
            5'd23:         cls = C_OUT;
            5'd24:         cls = C_MFHI;
            5'd25:         cls = C_MFLO;
            5'd27:         cls = C_HALT;
            default:       cls = C_NOP;
        endcase
    end

    // Map the immediate opcodes onto their ALU operation.
    always_comb begin
        case (opcode)
            5'd13:   imm_op = OP_AND;
            5'd14:   imm_op = OP_OR;
            default: imm_op = OP_ADD;
        endcase
    end

    // Next-state sequencing; the instruction class decides where execute ends.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = hold_q ? S_RESET : S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
                case (cls)
                    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP: state_d = S_T0;
                    C_HALT:                                   state_d = S_HALT;
                    default:                                  state_d = S_T4;
                endcase
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (cls == C_ALU || cls == C_IMM || cls == C_LDI) ? S_T0 : S_T6;
            S_T6:    state_d = (cls == C_LD) ? S_T7 : S_T0;
            S_T7:    state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // State register; clear forces RESET at once and arms the one-edge hold.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_RESET;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= 1'b0;
        end
    end

    // Strobe decode. It stays combinational because ir is loaded on the
    // T2->T3 edge, so a registered decode would see the previous opcode in T3;
    // it also lets clear drop every strobe without waiting for a clock.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        bus.op        = OP_ADD;
        bus.Gra       = 1'b0; bus.Grb      = 1'b0; bus.Grc      = 1'b0;
        bus.Rin       = 1'b0; bus.Rout     = 1'b0; bus.BAout    = 1'b0; bus.Cout = 1'b0;
        bus.PCout     = 1'b0; bus.PCin     = 1'b0; bus.IncPC    = 1'b0;
        bus.MARin     = 1'b0; bus.MDRin    = 1'b0; bus.MDRout   = 1'b0; bus.IRin = 1'b0;
        bus.Read      = 1'b0; bus.Write    = 1'b0;
        bus.Yin       = 1'b0; bus.Zlowin   = 1'b0; bus.Zhighin  = 1'b0;
        bus.Zlowout   = 1'b0; bus.Zhighout = 1'b0;
        bus.HIin      = 1'b0; bus.LOin     = 1'b0; bus.HIout    = 1'b0; bus.LOout = 1'b0;
        bus.InPortout = 1'b0; bus.OutPortin = 1'b0; bus.CONin   = 1'b0;

        case (state_q)
            S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; end
            S_T1: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
            S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            S_T3: begin
                case (cls)
                    C_ALU, C_IMM:      begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    C_LD, C_LDI, C_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                    C_MULDIV:          begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    C_BR:              begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
                    C_JR:              begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
                    C_IN:              begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    C_OUT:             begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1; end
                    C_MFHI:            begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    C_MFLO:            begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU:             begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; bus.op = opcode; end
                    C_IMM:             begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; bus.op = imm_op; end
                    C_LD, C_LDI, C_ST: begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; end
                    C_MULDIV: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; bus.Zhighin = 1'b1;
                        bus.op  = opcode;
                    end
                    C_BR:              begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_ALU, C_IMM, C_LDI: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    C_LD, C_ST:          begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
                    C_MULDIV:            begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
                    C_BR:                begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD:     begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                    C_ST:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Write = 1'b1; end
                    C_MULDIV: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
                    C_BR:     begin bus.Zlowout = 1'b1; bus.PCin = bus.branch_compare; end
                    default: ;
                endcase
            end
            S_T7: begin
                if (cls == C_LD) begin
                    bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
